// File: rtl/jmagcmp_pkg.sv
// Shared types and sizing helpers for the digit-serial magnitude comparator.
// Used by jseq_magnitude_comparator and its testbench.
package jmagcmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Encoding of a compare outcome; RES_EQ doubles as "no difference seen yet".
  localparam logic [1:0] RES_EQ = 2'd0;
  localparam logic [1:0] RES_GT = 2'd1;
  localparam logic [1:0] RES_LT = 2'd2;

  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  function automatic int cyc_width(input int width, input int digit);
    return $clog2(width / digit + 1);
  endfunction

endpackage

// File: rtl/jseq_magnitude_comparator_digit.sv
// Combinational DIGIT-bit unsigned compare; sign_inv flips the digit MSB of
// both operands so a two's complement top digit compares as offset-binary.
module jdigit_compare #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             sign_inv,
  output logic             gt,
  output logic             lt
);

  logic [DIGIT-1:0] ax;
  logic [DIGIT-1:0] bx;

  always_comb begin
    ax = a;
    bx = b;
    ax[DIGIT-1] = a[DIGIT-1] ^ sign_inv;
    bx[DIGIT-1] = b[DIGIT-1] ^ sign_inv;
    gt = (ax > bx);
    lt = (ax < bx);
  end

endmodule

// File: rtl/jseq_magnitude_comparator.sv
// Digit-serial MSB-first magnitude comparator with start/busy/done handshake.
// Define JSEQ_MAGCMP_SIGNED_EN for two's complement operands (default unsigned).
module jseq_magnitude_comparator
  import jmagcmp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int DIGIT      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [WIDTH-1:0]                     a,
  input  logic [WIDTH-1:0]                     b,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 aeqb,
  output logic                                 agtb,
  output logic                                 altb,
  output logic [cyc_width(WIDTH, DIGIT)-1:0]   cycles
);

  // Handshake: start is a request honoured only in IDLE; busy covers CMP and
  // DONE; done is a one-cycle pulse and the flags/cycles are valid from it
  // until the next accepted start.
  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = cyc_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [1:0]       first_res;
  logic [1:0]       dig_res;
  logic [1:0]       cur_res;
  logic             dig_gt;
  logic             dig_lt;
  logic             sign_inv;
  logic             finish;

  // cycles doubles as the digit index while scanning.
`ifdef JSEQ_MAGCMP_SIGNED_EN
  assign sign_inv = (cycles == '0);
`else
  assign sign_inv = 1'b0;
`endif

  jdigit_compare #(.DIGIT(DIGIT)) u_digit (
    .a        (sa[WIDTH-1 -: DIGIT]),
    .b        (sb[WIDTH-1 -: DIGIT]),
    .sign_inv (sign_inv),
    .gt       (dig_gt),
    .lt       (dig_lt)
  );

  always_comb begin
    dig_res = RES_EQ;
    if (dig_gt)      dig_res = RES_GT;
    else if (dig_lt) dig_res = RES_LT;
    // The first latched difference wins over any later digit.
    cur_res = (first_res != RES_EQ) ? first_res : dig_res;
    finish  = (cycles == LAST) || ((EARLY_EXIT != 0) && (dig_res != RES_EQ));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = CMP;
      CMP: begin
        busy = 1'b1;
        if (finish) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sa        <= '0;
      sb        <= '0;
      cycles    <= '0;
      first_res <= RES_EQ;
      aeqb      <= 1'b0;
      agtb      <= 1'b0;
      altb      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sa        <= a;
          sb        <= b;
          cycles    <= '0;
          first_res <= RES_EQ;
          aeqb      <= 1'b0;
          agtb      <= 1'b0;
          altb      <= 1'b0;
        end
        CMP: begin
          sa        <= sa << DIGIT;
          sb        <= sb << DIGIT;
          cycles    <= cycles + CW'(1);
          first_res <= cur_res;
          if (finish) begin
            aeqb <= (cur_res == RES_EQ);
            agtb <= (cur_res == RES_GT);
            altb <= (cur_res == RES_LT);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jseq_magnitude_comparator.sv
// Scoreboard bench: three instances (early exit, full scan, single digit)
// share stimulus; a reference model pushes expected results per instance.
module tb_jseq_magnitude_comparator;
  import jmagcmp_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [2:0] bsy, dn, eq, gt, lt;
  logic [cyc_width(16, 4)-1:0]  cy0;
  logic [cyc_width(16, 4)-1:0]  cy1;
  logic [cyc_width(16, 16)-1:0] cy2;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  // Entry layout: {done_cycle[15:0], cycles[3:0], flags{lt,gt,eq}}
  logic [22:0] exp_q0[$];
  logic [22:0] exp_q1[$];
  logic [22:0] exp_q2[$];
  logic [6:0]  last_res[3];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jseq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) dut_ee (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(bsy[0]), .done(dn[0]), .aeqb(eq[0]), .agtb(gt[0]), .altb(lt[0]), .cycles(cy0));

  jseq_magnitude_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(0)) dut_full (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(bsy[1]), .done(dn[1]), .aeqb(eq[1]), .agtb(gt[1]), .altb(lt[1]), .cycles(cy1));

  jseq_magnitude_comparator #(.WIDTH(16), .DIGIT(16), .EARLY_EXIT(1)) dut_one (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(bsy[2]), .done(dn[2]), .aeqb(eq[2]), .agtb(gt[2]), .altb(lt[2]), .cycles(cy2));

  // ---------------- reference model ----------------
  function automatic logic [2:0] ref_flags(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef JSEQ_MAGCMP_SIGNED_EN
    if ($signed(x) > $signed(y)) return 3'b010;
    if ($signed(x) < $signed(y)) return 3'b100;
`else
    if (x > y) return 3'b010;
    if (x < y) return 3'b100;
`endif
    return 3'b001;
  endfunction

  // 1-based index of the first differing digit, or the digit count if equal.
  function automatic int first_diff(input logic [W-1:0] x, input logic [W-1:0] y, input int digit);
    int n = W / digit;
    int unsigned diff = 32'(x ^ y);
    int unsigned mask = (32'd1 << digit) - 32'd1;
    for (int i = 0; i < n; i++) begin
      if (((diff >> (W - digit * (i + 1))) & mask) != 0) return i + 1;
    end
    return n;
  endfunction

  task automatic push_expect(input logic [W-1:0] x, input logic [W-1:0] y, input int sc);
    logic [2:0] f = ref_flags(x, y);
    int d0 = first_diff(x, y, 4);
    int d1 = W / 4;
    int d2 = 1;
    exp_q0.push_back({16'(sc + 1 + d0), 4'(d0), f});
    exp_q1.push_back({16'(sc + 1 + d1), 4'(d1), f});
    exp_q2.push_back({16'(sc + 1 + d2), 4'(d2), f});
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic check_inst(input int k, input logic bz, input logic d,
                            input logic [2:0] fl, input int cv);
    logic [22:0] e = '0;
    bit have = 1'b0;
    if (d) begin
      case (k)
        0: if (exp_q0.size() != 0) begin e = exp_q0.pop_front(); have = 1'b1; end
        1: if (exp_q1.size() != 0) begin e = exp_q1.pop_front(); have = 1'b1; end
        default: if (exp_q2.size() != 0) begin e = exp_q2.pop_front(); have = 1'b1; end
      endcase
      tests++;
      if (!have) begin
        fails++;
        $display("FAIL done_unexpected[%0d]: got done=1 required no pulse (t=%0t)", k, $time);
      end else begin
        chk($sformatf("flags[%0d]", k), 32'(fl), 32'(e[2:0]));
        chk($sformatf("cycles[%0d]", k), 32'(cv), 32'(e[6:3]));
        chk($sformatf("latency[%0d]", k), 32'(cyc[15:0]), 32'(e[22:7]));
        chk($sformatf("busy_in_done[%0d]", k), 32'(bz), 32'd1);
        last_res[k] = e[6:0];
      end
    end else if (bz) begin
      chk($sformatf("flags_while_busy[%0d]", k), 32'(fl), 32'd0);
    end else begin
      chk($sformatf("hold[%0d]", k), 32'({cv[3:0], fl}), 32'(last_res[k]));
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q0.delete();
      exp_q1.delete();
      exp_q2.delete();
      for (int k = 0; k < 3; k++) last_res[k] = '0;
    end else begin
      check_inst(0, bsy[0], dn[0], {lt[0], gt[0], eq[0]}, int'(cy0));
      check_inst(1, bsy[1], dn[1], {lt[1], gt[1], eq[1]}, int'(cy1));
      check_inst(2, bsy[2], dn[2], {lt[2], gt[2], eq[2]}, int'(cy2));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bsy != 3'b000 && n < 50) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(bsy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bsy), 32'd0);
    chk({tag, "_done"}, 32'(dn), 32'd0);
    chk({tag, "_flags"}, 32'({eq, gt, lt}), 32'd0);
    chk({tag, "_cycles"}, 32'({cy0, cy1, cy2}), 32'd0);
  endtask

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input bit poke);
    wait_idle();
    a = x;
    b = y;
    start = 1'b1;
    push_expect(x, y, cyc);
    tick();
    if (poke) begin
      a = 16'hFFFF;
      tick();
    end
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] x, y;
    int mode, k;

    rst_n = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    issue(16'h0002, 16'h0002, 1'b0);
    issue(16'h3000, 16'h4000, 1'b0);
    issue(16'h0050, 16'h0030, 1'b0);
    issue(16'h1234, 16'h1234, 1'b1);

    // Reset in the middle of a scan: no done pulse, outputs return to zero.
    wait_idle();
    a = 16'h0001;
    b = 16'h0002;
    start = 1'b1;
    push_expect(a, b, cyc);
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    tick();

    issue(16'h0001, 16'h0002, 1'b0);
    issue(16'hFFFF, 16'h0001, 1'b0);
    issue(16'h8000, 16'h7FFF, 1'b0);
    issue(16'h0000, 16'hFFFF, 1'b0);

    for (int i = 0; i < 150; i++) begin
      mode = $urandom_range(0, 3);
      x = 16'($urandom);
      case (mode)
        0: y = 16'($urandom);
        1: y = x;
        2: begin
          k = $urandom_range(0, 3);
          y = x ^ (16'($urandom_range(1, 15)) << (12 - 4 * k));
        end
        default: begin
          x = 16'($urandom_range(0, 20));
          y = 16'($urandom_range(0, 20));
        end
      endcase
      issue(x, y, ($urandom_range(0, 7) == 0));
    end

    wait_idle();
    repeat (3) tick();
    chk("pending_q0", 32'(exp_q0.size()), 32'd0);
    chk("pending_q1", 32'(exp_q1.size()), 32'd0);
    chk("pending_q2", 32'(exp_q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jseq_magnitude_comparator.md
Name: jseq_magnitude_comparator

Overview:
- Parametrised, digit-serial, MSB-first magnitude comparator.
- Replaces the fixed 4-bit combinational comparator for wide operands in timing-critical paths.
- Compares DIGIT bits per clock, with an optional early exit on the first differing digit.
- Start/busy/done handshake; the registered EQ/GT/LT result is held until the next start.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits compared per clock; 1 <= DIGIT <= WIDTH.
- EARLY_EXIT, 1, 1 = finish on the first differing digit; 0 = always scan all N = WIDTH/DIGIT digits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; captured on the accepted start edge.
- b  input  WIDTH  operand B; captured on the accepted start edge.
- busy  output  1  high in CMP and DONE.
- done  output  1  one-cycle pulse; result valid from this cycle.
- aeqb  output  1  A == B.
- agtb  output  1  A > B.
- altb  output  1  A < B.
- cycles  output  $clog2(N+1)  number of digit compares used by the last operation.

Behaviour:
- States: IDLE, CMP, DONE. Reset (rst_n low at a clock edge) forces:
  - state = IDLE;
  - busy = done = aeqb = agtb = altb = 0;
  - cycles = 0;
  - shift registers are cleared.
- IDLE:
  - start = 1 at an edge loads a and b into shift registers;
  - clears digit index, cycles, and all three flags;
  - moves to CMP.
  - start = 0: remain in IDLE.
- CMP: each edge compares the top DIGIT bits of both shift registers, shifts both left by DIGIT, and increments cycles.
  - Digits differ and EARLY_EXIT = 1: set agtb/altb from the digit compare; go to DONE.
  - Digits differ and EARLY_EXIT = 0: latch the first difference only (later digits cannot override it); continue.
  - Last digit (index N-1) processed: finalise the flags and go to DONE. aeqb = 1 if no difference was latched.
- DONE:
  - done = 1 for exactly one cycle;
  - next edge goes to IDLE unconditionally;
  - start is ignored in DONE.
- Latency: done is high d cycles after the start edge, where d = 1-based index of the first differing digit (N if equal, and always N when EARLY_EXIT = 0). Back-to-back operations need d+2 cycles.
- Flags:
  - exactly one of aeqb/agtb/altb is high after done;
  - all three are 0 while busy;
  - flags and cycles hold until the next accepted start.
- start while busy: ignored; captured operands do not change. Changes on a/b after capture have no effect.
- Reset mid-CMP or mid-DONE: immediate return to reset values; no done pulse.
- WIDTH == DIGIT: single compare cycle (N = 1).

Optional Feature:
- Macro: JSEQ_MAGCMP_SIGNED_EN.
- Defined: operands are two's complement. The MSB digit (index 0) is compared with each operand's sign bit inverted (offset-binary); other digits are compared unsigned.
- Undefined: unsigned comparison only; no sign logic is synthesised.

Decomposition:
- Package jmagcmp_pkg:
  - state typedef (IDLE/CMP/DONE);
  - result encoding localparams (RES_EQ, RES_GT, RES_LT);
  - function computing N and the cycles width from WIDTH/DIGIT.
- Sub-module jdigit_compare: combinational DIGIT-bit compare producing gt/lt, with a sign_inv input used for the MSB digit. Instantiated once in the top.

Test Plan (WIDTH = 16, DIGIT = 4, EARLY_EXIT = 1 unless stated):
1. a = 16'h0002, b = 16'h0002, start pulse -> done 4 cycles after the start edge; aeqb = 1, agtb = altb = 0; cycles = 4.
2. a = 16'h3000, b = 16'h4000 -> done 1 cycle after the start edge; altb = 1; cycles = 1. Repeat with EARLY_EXIT = 0 -> done at cycle 4, altb = 1, cycles = 4.
3. a = 16'h0050, b = 16'h0030 -> done at cycle 3; agtb = 1; cycles = 3. Flags stay 0 while busy and hold after done until the next start.
4. Start a = 16'h1234, b = 16'h1234; one cycle later drive start = 1 with a = 16'hFFFF -> second start ignored; result aeqb = 1 at cycle 4; exactly one done pulse.
5. Start a = 16'h0001, b = 16'h0002; pull rst_n low at cycle 2 -> all outputs 0 next cycle; no done pulse. New start after reset completes normally.
6. a = 16'hFFFF, b = 16'h0001:
   - with JSEQ_MAGCMP_SIGNED_EN defined -> altb = 1, cycles = 1;
   - without it -> agtb = 1, cycles = 1.
